// File: rtl/mips_pkg.sv
// Shared types and constants for the instruction-fetch path and the IF/ID stage.
package mips_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    // Byte distance between sequential instruction fetches
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;

    // One fetched instruction paired with the byte address it came from
    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer holding a fetched instruction while decode is stalled.
// A load in the same cycle as an unload replaces the entry; flush wins over both.
module fetch_skid_buf
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         load,
    input  logic         unload,
    input  fetch_entry_t din,
    output logic         valid,
    output fetch_entry_t dout
);

    // Entry storage: flush empties, load fills, unload alone empties
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= 1'b0;
            dout  <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            dout  <= din;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

    // Loading into a full entry without draining it would drop an instruction
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(load && valid && !unload && !flush))
                else $error("fetch_skid_buf overflow: load into occupied entry");
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the iCache address, pairs each
// returned word with its PC and hands it to decode through registered outputs.
// The one-cycle iCache latency under decode stall is absorbed by a skid entry.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = mips_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] iCacheReadAddr,
    input  logic [31:0] iCacheReadData,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    logic [31:0]  pc_q;
    logic         inflight_q;
    logic [31:0]  inflight_pc_q;

    logic         out_valid_q;
    fetch_entry_t out_q;
    logic [31:0]  out_pc_plus4_q;

    logic         skid_valid;
    fetch_entry_t skid_entry;

    fetch_entry_t arr_entry;
    fetch_entry_t nxt_entry;
    logic         out_free;
    logic         issue_en;
    logic         skid_load;
    logic         skid_unload;

    assign iCacheReadAddr = pc_q;

    // Word returning this cycle belongs to the request issued on the last edge
    assign arr_entry = '{instr: iCacheReadData, pc: inflight_pc_q};

    // Skid content is older than the arriving word, so it drains first
    assign nxt_entry = skid_valid ? skid_entry : arr_entry;

    assign out_free = !out_valid_q || !id_stall;

    // Stop issuing once a stalled output plus one more word would fill the skid
    assign issue_en = !(id_stall && out_valid_q && (skid_valid || inflight_q));

    assign skid_unload = out_free && skid_valid;
    assign skid_load   = inflight_q && (!out_free || skid_valid);

    fetch_skid_buf u_skid (
        .clk    (clk),
        .rst    (rst),
        .flush  (redirect_valid),
        .load   (skid_load),
        .unload (skid_unload),
        .din    (arr_entry),
        .valid  (skid_valid),
        .dout   (skid_entry)
    );

    // PC and in-flight request tracking; redirect overrides issue and stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q       <= {redirect_pc[31:2], 2'b00};
            inflight_q <= 1'b0;
        end else if (issue_en) begin
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
            pc_q          <= pc_q + PC_STEP;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    // Output register toward decode; holds while decode stalls a valid entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q    <= 1'b0;
            out_q          <= '0;
            out_pc_plus4_q <= 32'd4;
        end else if (redirect_valid) begin
            out_valid_q <= 1'b0;
        end else if (out_free) begin
            if (skid_valid || inflight_q) begin
                out_valid_q    <= 1'b1;
                out_q          <= nxt_entry;
                out_pc_plus4_q <= nxt_entry.pc + 32'd4;
            end else begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign if_valid    = out_valid_q;
    assign if_instr    = out_q.instr;
    assign if_pc       = out_q.pc;
    assign if_pc_plus4 = out_pc_plus4_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a registered-read iCache model.
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] iCacheReadAddr;
    logic [31:0] iCacheReadData;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int checks = 0;
    int errors = 0;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .iCacheReadAddr (iCacheReadAddr),
        .iCacheReadData (iCacheReadData),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_stall       (id_stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents; unlisted addresses return a tagged pattern
    function automatic logic [31:0] imem(input logic [31:0] a);
        case (a)
            32'h0000_0000: imem = 32'h2001_0002;
            32'h0000_0004: imem = 32'h2002_0004;
            32'h0000_0008: imem = 32'h2003_0006;
            32'h0000_000C: imem = 32'h2004_0008;
            32'h0000_0030: imem = 32'h200c_0010;
            32'h0000_002C: imem = 32'h1483_0004;
            default:       imem = 32'hF000_0000 | a;
        endcase
    endfunction

    // Registered-read iCache
    always @(posedge clk) iCacheReadData <= imem(iCacheReadAddr);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", tag, obs, exp);
            end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] pc, input logic [31:0] instr);
        chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
        chk({tag, ".pc"}, if_pc, pc);
        chk({tag, ".instr"}, if_instr, instr);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        rst            = 1'b1;
        id_stall       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Reset held for three cycles
        repeat (3) step();
        chk_idle("rst");
        chk("rst.pc", if_pc, 32'h0);
        chk("rst.instr", if_instr, 32'h0);
        chk("rst.pc4", if_pc_plus4, 32'h4);
        chk("rst.addr", iCacheReadAddr, 32'h0);
        rst = 1'b0;

        // Free run from the reset PC
        step(); chk_idle("run.e1");
        step(); chk_out("run.e2", 32'h0, 32'h2001_0002);
        chk("run.e2.pc4", if_pc_plus4, 32'h4);
        step(); chk_out("run.e3", 32'h4, 32'h2002_0004);
        step(); chk_out("run.e4", 32'h8, 32'h2003_0006);

        // Three-cycle stall while pc 8 is presented
        id_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall.hold", 32'h8, 32'h2003_0006);
            chk("stall.addr", iCacheReadAddr, 32'h10);
        end
        id_stall = 1'b0;
        step(); chk_out("stall.rel1", 32'hC, 32'h2004_0008);
        step(); chk_out("stall.rel2", 32'h10, imem(32'h10));

        // Redirect to 0x30
        redirect_valid = 1'b1;
        redirect_pc    = 32'h30;
        step(); chk_idle("redir.b1");
        redirect_valid = 1'b0;
        step(); chk_idle("redir.b2");
        step(); chk_out("redir.tgt", 32'h30, 32'h200c_0010);
        chk("redir.pc4", if_pc_plus4, 32'h34);

        // Fill the skid under stall, then redirect in the same cycle as stall
        id_stall = 1'b1;
        step(); chk_out("rs.hold", 32'h30, 32'h200c_0010);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0;
        step(); chk_idle("rs.b1");
        redirect_valid = 1'b0;
        step(); chk_idle("rs.b2");
        step(); chk_out("rs.tgt", 32'h0, 32'h2001_0002);
        id_stall = 1'b0;
        step(); chk_out("rs.next", 32'h4, 32'h2002_0004);

        // Misaligned target is forced to word alignment
        redirect_valid = 1'b1;
        redirect_pc    = 32'h2F;
        step(); chk_idle("mis.b1");
        redirect_valid = 1'b0;
        step(); chk_idle("mis.b2");
        step(); chk_out("mis.tgt", 32'h2C, 32'h1483_0004);
        chk("mis.pc4", if_pc_plus4, 32'h30);

        // Top-of-address-space wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step(); chk_idle("wrap.b1");
        redirect_valid = 1'b0;
        step(); chk_idle("wrap.b2");
        chk("wrap.addr", iCacheReadAddr, 32'h0);
        step(); chk_out("wrap.top", 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        chk("wrap.pc4", if_pc_plus4, 32'h0);
        step(); chk_out("wrap.zero", 32'h0, 32'h2001_0002);
        step(); chk_out("wrap.four", 32'h4, 32'h2002_0004);

        // Async reset between edges with output valid and skid full
        id_stall = 1'b1;
        step(); chk_out("arst.pre", 32'h4, 32'h2002_0004);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("arst.now");
        chk("arst.pc", if_pc, 32'h0);
        chk("arst.pc4", if_pc_plus4, 32'h4);
        chk("arst.addr", iCacheReadAddr, 32'h0);
        step();
        chk_idle("arst.held");
        rst      = 1'b0;
        id_stall = 1'b0;
        step(); chk_idle("arst.e1");
        step(); chk_out("arst.e2", 32'h0, 32'h2001_0002);
        step(); chk_out("arst.e3", 32'h4, 32'h2002_0004);
        step(); chk_out("arst.e4", 32'h8, 32'h2003_0006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage that sits directly upstream of the iCache.
- Owns the PC and drives the iCache read address every cycle.
- Pairs each returned instruction with its PC and presents it to decode through a registered valid/stall interface.
- Handles branch/jump redirects (flush) and decode back-pressure; the registered 1-cycle iCache latency is absorbed by a one-entry skid buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
PC_STEP, 4, byte increment per sequential fetch

Ports:
clk  input  1  single clock; all state updates on its rising edge
rst  input  1  reset; asynchronous, active-high
iCacheReadAddr  output  32  byte address to iCache; equals pc_q combinationally
iCacheReadData  input  32  iCache data, valid one edge after the address was presented
redirect_valid  input  1  one-cycle pulse requesting a PC change from a later stage
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0)
id_stall  input  1  decode cannot accept the current output this cycle
if_valid  output  1  if_instr/if_pc hold a valid fetched instruction
if_instr  output  32  fetched instruction word
if_pc  output  32  byte address of if_instr
if_pc_plus4  output  32  if_pc + 4, registered with if_pc

Behaviour:
- State:
  - pc_q
  - inflight_q, inflight_pc_q: request issued last edge, data arriving this cycle
  - skid_valid/skid_instr/skid_pc
  - output regs if_valid/if_instr/if_pc/if_pc_plus4
- Reset (async, immediate, independent of clk):
  - pc_q = RESET_PC
  - inflight_q, skid_valid, if_valid = 0
  - if_instr, if_pc, skid_* = 0; if_pc_plus4 = 4
- Arrival: when inflight_q = 1, the word {iCacheReadData, inflight_pc_q} is an arriving entry this cycle.
- Accept condition: out_free = !if_valid || !id_stall.
- Output update when out_free:
  - If skid_valid: output <= skid, and skid <= arriving entry (or skid_valid <= 0 if none).
  - Else if arriving: output <= arriving.
  - Else: if_valid <= 0.
- Output update when not out_free: output holds; an arriving entry goes into skid.
  - The issue rule below guarantees the skid is empty at that point. Overflow is a design error; assert in sim.
- Issue rule:
  - issue_en = !(id_stall && if_valid && (skid_valid || inflight_q)).
  - On issue: inflight_q <= 1, inflight_pc_q <= pc_q, pc_q <= pc_q + PC_STEP.
  - On no issue: inflight_q <= 0, pc_q holds.
- iCache reads unconditionally. Data for non-issued cycles is ignored.
- PC arithmetic is 32-bit modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0.
- Redirect has highest priority (beats stall, issue and arrival in the same cycle):
  - pc_q <= {redirect_pc[31:2], 2'b00}
  - inflight_q, skid_valid, if_valid <= 0
  - No instruction fetched before the redirect ever reaches decode after it.
- Latency:
  - pc_q = A at edge n → if_valid with if_pc = A after edge n+2.
  - Sustained throughput is 1 instruction/cycle with no stalls.
  - After a redirect edge, if_valid stays low for exactly 2 cycles.
- Stall: no instruction is lost or duplicated across any stall length. Order is strictly PC-sequential between redirects.
- Reset asserted mid-operation discards all state, including the skid and in-flight data. The first fetch after deassertion is RESET_PC.

Decomposition:
- Shared package mips_pkg:
  - INSTR_W = 32, ADDR_W = 32
  - PC_STEP constant
  - typedef struct packed fetch_entry_t {instr, pc}, used for the skid and output regs and reused by the IF/ID stage
- One natural sub-module: fetch_skid_buf
  - One-entry buffer with load/unload/flush, storing fetch_entry_t.
  - Instantiated once by fetch_unit.

Test Plan:
- Bench iCache model: registered read; icache[0]=32'h2001_0002, [4]=32'h2002_0004, [8]=32'h2003_0006, [12]=32'h2004_0008, [48]=32'h200c_0010, [44]=32'h1483_0004.
1. Reset and free-run: rst high 3 cycles, release, id_stall=0 → if_valid rises after 2nd edge; (if_pc, if_instr) = (0, 2001_0002), (4, 2002_0004), (8, 2003_0006), (12, 2004_0008) on consecutive cycles.
2. Stall: assert id_stall for 3 cycles while if_pc=8 → if_pc=8 and if_instr=2003_0006 hold; after release, if_pc=12 then 16 on consecutive cycles, with no gap, loss or duplicate.
3. Redirect: pulse redirect_valid with redirect_pc=32'h30 while if_pc=0x10 → if_valid=0 for 2 cycles, then if_pc=0x30, if_instr=200c_0010, if_pc_plus4=0x34.
4. Redirect with stall: redirect_valid=1 and id_stall=1 in the same cycle with skid full → skid flushed, if_valid=0 next cycle, next valid if_pc = target; no stale instruction appears.
5. Misaligned target and wrap: redirect_pc=32'h2F → first fetch 0x2C with instr 1483_0004; separately, redirect_pc=32'hFFFF_FFFC → next if_pc after it is 0.
6. Async reset mid-stream: assert rst between clock edges while if_valid=1 and the skid is full → if_valid=0 and if_pc=0 before the next edge; after release the fetch sequence restarts at 0.
